rb_arbiter: RTL

RB_ARBITER -- requirements
Module: rb_arbiter

---
 rtl/rb_arbiter_pkg.sv | 19 +
 rtl/rb_arbiter_rr_arb2.sv | 28 ++
 rtl/rb_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rb_arbiter_pkg.sv
// rb_arbiter shared types and defaults
// FSM encoding and owner tag for the register-bank arbiter
package rb_arbiter_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RSP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/rb_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick with pointer
// pointer remembers the last winner; reset favours a
module rr_arb2 (
  input  logic clk,
  input  logic reset_all_n,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic pick_b,
  output logic any
);

  logic last_b;

  always_comb begin
    any    = req_a | req_b;
    pick_b = req_b & (~req_a | ~last_b);
  end

  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      last_b <= 1'b1;
    end else if (take && any) begin
      last_b <= pick_b;
    end
  end

endmodule

// File: rtl/rb_arbiter.sv
// rb_arbiter: two requesters sharing one register bank
// one command in flight: IDLE -> ISSUE (-> RSP for reads) -> IDLE
module rb_arbiter
  import rb_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_all_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] rs_a,
  input  logic [AW-1:0] rt_a,
  input  logic [AW-1:0] rd_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata1_a,
  output logic [DW-1:0] rdata2_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] rs_b,
  input  logic [AW-1:0] rt_b,
  input  logic [AW-1:0] rd_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata1_b,
  output logic [DW-1:0] rdata2_b,
  output logic [AW-1:0] rb_rs,
  output logic [AW-1:0] rb_rt,
  output logic [AW-1:0] rb_rd,
  output logic [DW-1:0] rb_in1,
  output logic          rb_read,
  output logic          rb_write,
  output logic          rb_enable,
  input  logic [DW-1:0] rb_out1,
  input  logic [DW-1:0] rb_out2,
  output logic          busy
);

  state_e        state_q;
  state_e        state_d;
  owner_e        owner_q;
  logic          we_q;
  logic [AW-1:0] rs_q;
  logic [AW-1:0] rt_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] wd_q;

  logic pick_b;
  logic any;
  logic take;
  logic in_issue;
  logic in_rsp;
  logic own_b;

  rr_arb2 u_rr (
    .clk         (clk),
    .reset_all_n (reset_all_n),
    .req_a       (req_a),
    .req_b       (req_b),
    .take        (take),
    .pick_b      (pick_b),
    .any         (any)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = we_q ? IDLE : RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // winner's command is frozen here and drives the bank pins
  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      owner_q <= OWN_A;
      we_q    <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      wd_q    <= '0;
    end else if (take) begin
      owner_q <= pick_b ? OWN_B : OWN_A;
      we_q    <= pick_b ? we_b : we_a;
      rs_q    <= pick_b ? rs_b : rs_a;
      rt_q    <= pick_b ? rt_b : rt_a;
      rd_q    <= pick_b ? rd_b : rd_a;
      wd_q    <= pick_b ? wdata_b : wdata_a;
    end
  end

  always_comb begin
    in_issue = (state_q == ISSUE);
    in_rsp   = (state_q == RSP);
    own_b    = (owner_q == OWN_B);
  end

  always_comb begin
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    rvalid_a  = 1'b0;
    rvalid_b  = 1'b0;
    rb_read   = 1'b0;
    rb_write  = 1'b0;
    rb_enable = 1'b0;
    unique case (1'b1)
      in_issue: begin
        gnt_a     = ~own_b;
        gnt_b     = own_b;
        rb_read   = ~we_q;
        rb_write  = we_q;
        rb_enable = 1'b1;
      end
      in_rsp: begin
        rvalid_a = ~own_b;
        rvalid_b = own_b;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign rb_rs  = rs_q;
  assign rb_rt  = rt_q;
  assign rb_rd  = rd_q;
  assign rb_in1 = wd_q;

  // bank output is valid at the edge that closes a read ISSUE
  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      rdata1_a <= '0;
      rdata2_a <= '0;
      rdata1_b <= '0;
      rdata2_b <= '0;
    end else if (in_issue && !we_q) begin
      if (own_b) begin
        rdata1_b <= rb_out1;
        rdata2_b <= rb_out2;
      end else begin
        rdata1_a <= rb_out1;
        rdata2_a <= rb_out2;
      end
    end
  end

  a_gnt_excl : assert property (
    @(posedge clk) disable iff (!reset_all_n)
    !(gnt_a && gnt_b));

  a_rv_excl : assert property (
    @(posedge clk) disable iff (!reset_all_n)
    !(rvalid_a && rvalid_b));

  a_rw_excl : assert property (
    @(posedge clk) disable iff (!reset_all_n)
    !(rb_read && rb_write));

  a_en_issue : assert property (
    @(posedge clk) disable iff (!reset_all_n)
    rb_enable == in_issue);

endmodule
